// File: rtl/sram_2p_march_bist_ctrl_pkg.sv
// Shared state encoding and March C- element table for the 2P SRAM BIST sequencer.
// Pure declarations: no latency, no flow control.
package sram_bist_pkg;

  localparam int         NUM_ELEM  = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // two_op elements read then write each address; single-op elements use has_rd to pick the op
  typedef struct packed {
    logic down;
    logic two_op;
    logic has_rd;
    logic rd_inv;
    logic wr_inv;
  } elem_t;

  localparam elem_t [NUM_ELEM-1:0] ELEM_TAB = {
    elem_t'{down: 1'b0, two_op: 1'b0, has_rd: 1'b1, rd_inv: 1'b0, wr_inv: 1'b0},  // E5 up(r D)
    elem_t'{down: 1'b1, two_op: 1'b1, has_rd: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0},  // E4 down(r ~D, w D)
    elem_t'{down: 1'b1, two_op: 1'b1, has_rd: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1},  // E3 down(r D, w ~D)
    elem_t'{down: 1'b0, two_op: 1'b1, has_rd: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0},  // E2 up(r ~D, w D)
    elem_t'{down: 1'b0, two_op: 1'b1, has_rd: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1},  // E1 up(r D, w ~D)
    elem_t'{down: 1'b0, two_op: 1'b0, has_rd: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0}   // E0 up(w D)
  };

  function automatic logic elem_is_read(input logic two_op, input logic has_rd, input logic phase);
    return has_rd && !(two_op && phase);
  endfunction

endpackage

// File: rtl/sram_2p_march_bist_ctrl_if.sv
// Macro-facing BIST pin bundle: controller drives op pins, macro returns read data.
// Op pins are registered in the controller; read data is valid the cycle after a read op.
interface sram_2p_march_bist_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              bist_en;
  logic              bist_men;
  logic              bist_wen;
  logic              bist_ren;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_din;
  logic [DATA_W-1:0] bist_bm;
  logic [DATA_W-1:0] bist_dout;

  modport master (
    output bist_en,
    output bist_men,
    output bist_wen,
    output bist_ren,
    output bist_addr,
    output bist_din,
    output bist_bm,
    input  bist_dout
  );

  modport slave (
    input  bist_en,
    input  bist_men,
    input  bist_wen,
    input  bist_ren,
    input  bist_addr,
    input  bist_din,
    input  bist_bm,
    output bist_dout
  );

endinterface

// File: rtl/sram_2p_march_bist_ctrl_addr_gen.sv
// Loadable up/down address counter; load/step take effect on the next clock edge.
// No backpressure: step is honoured every cycle it is asserted.
module sram_bist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              dir,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic dir_q;

  // dir=1 counts down from the top address, dir=0 counts up from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      addr  <= dir ? '1 : '0;
      dir_q <= dir;
    end else if (step) begin
      addr  <= dir_q ? (addr - ADDR_W'(1)) : (addr + ADDR_W'(1));
    end
  end

  assign last = dir_q ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_2p_march_bist_ctrl.sv
// March C- BIST sequencer for one 2P SRAM port; ops are registered, read data compared one cycle later.
// Runs free once started (no backpressure); start is ignored unless the sequencer is idle.
module sram_2p_march_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] BG_PATTERN = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       fail_o,
  output logic [ADDR_W-1:0]          fail_addr_o,
  output logic [2:0]                 fail_elem_o,
  sram_2p_march_bist_ctrl_if.master  bist
);

  localparam logic [DATA_W-1:0] PAT_D = BG_PATTERN;
  localparam logic [DATA_W-1:0] PAT_N = ~BG_PATTERN;

  state_e            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic              phase_q, phase_d;
  logic              issue;
  logic              ag_load, ag_dir, ag_step;
  logic [ADDR_W-1:0] addr;
  logic              addr_last;
  logic              cur_rd, nxt_rd;
  logic              busy_d, done_d, en_q, en_d;
  logic              men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic [DATA_W-1:0] din_q, din_d, bm_q, bm_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic [2:0]        cmp_elem_q;
  logic              fail_clr, mismatch;
  logic              fail_d;
  logic [ADDR_W-1:0] fail_addr_d;
  logic [2:0]        fail_elem_d;

  sram_bist_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .load  (ag_load),
    .dir   (ag_dir),
    .step  (ag_step),
    .addr  (addr),
    .last  (addr_last)
  );

  assign cur_rd = elem_is_read(ELEM_TAB[elem_q].two_op, ELEM_TAB[elem_q].has_rd, phase_q);
  assign nxt_rd = elem_is_read(ELEM_TAB[elem_d].two_op, ELEM_TAB[elem_d].has_rd, phase_d);

  // elem/phase/addr always describe the op currently on the pins; *_d describe the next one
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    phase_d   = phase_q;
    issue     = 1'b0;
    ag_load   = 1'b0;
    ag_dir    = 1'b0;
    ag_step   = 1'b0;
    busy_d    = busy_o;
    done_d    = done_o;
    en_d      = en_q;
    cmp_vld_d = 1'b0;
    exp_d     = exp_q;
    fail_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          elem_d   = '0;
          phase_d  = 1'b0;
          ag_load  = 1'b1;
          ag_dir   = ELEM_TAB[0].down;
          issue    = 1'b1;
          busy_d   = 1'b1;
          en_d     = 1'b1;
          done_d   = 1'b0;
          fail_clr = 1'b1;
        end
      end
      RUN: begin
        if (cur_rd) begin
          cmp_vld_d = 1'b1;
          exp_d     = ELEM_TAB[elem_q].rd_inv ? PAT_N : PAT_D;
        end
        if (ELEM_TAB[elem_q].two_op && !phase_q) begin
          phase_d = 1'b1;
          issue   = 1'b1;
        end else if (!addr_last) begin
          phase_d = 1'b0;
          ag_step = 1'b1;
          issue   = 1'b1;
        end else if (elem_q == LAST_ELEM) begin
          // reload to address 0 so the pins idle at zero outside RUN
          state_d = DRAIN;
          phase_d = 1'b0;
          ag_load = 1'b1;
          ag_dir  = 1'b0;
        end else begin
          elem_d  = elem_q + 3'd1;
          phase_d = 1'b0;
          ag_load = 1'b1;
          ag_dir  = ELEM_TAB[elem_d].down;
          issue   = 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        en_d    = 1'b0;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    men_d = 1'b0;
    wen_d = 1'b0;
    ren_d = 1'b0;
    din_d = '0;
    bm_d  = '0;
    if (issue) begin
      men_d = 1'b1;
      ren_d = nxt_rd;
      wen_d = !nxt_rd;
      if (!nxt_rd) begin
        din_d = ELEM_TAB[elem_d].wr_inv ? PAT_N : PAT_D;
        bm_d  = '1;
      end
    end
  end

  assign mismatch = cmp_vld_q && (|(bist.bist_dout ^ exp_q));

  // only the first mismatch is located; later ones just keep the flag set
  always_comb begin
    fail_d      = fail_o;
    fail_addr_d = fail_addr_o;
    fail_elem_d = fail_elem_o;
    if (fail_clr) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_o) begin
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_q      <= '0;
      phase_q     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      en_q        <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      din_q       <= '0;
      bm_q        <= '0;
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= '0;
    end else begin
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      en_q        <= en_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
      cmp_vld_q   <= cmp_vld_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= addr;
      cmp_elem_q  <= elem_q;
      fail_o      <= fail_d;
      fail_addr_o <= fail_addr_d;
      fail_elem_o <= fail_elem_d;
    end
  end

  assign bist.bist_en   = en_q;
  assign bist.bist_men  = men_q;
  assign bist.bist_wen  = wen_q;
  assign bist.bist_ren  = ren_q;
  assign bist.bist_addr = addr;
  assign bist.bist_din  = din_q;
  assign bist.bist_bm   = bm_q;

endmodule
